// File: rtl/tick_bcd_stopwatch.sv
// MM:SS stopwatch advancing four cascaded BCD digits on synchronised tick_in rising edges, under start/stop/clear control.
// Latency: a tick_in rise before edge 1 updates the digits on edge SYNC_STAGES+1; the block has no backpressure, and every tick seen while running is counted.
module tick_bcd_stopwatch #(
    parameter int SYNC_STAGES = 2,
    parameter bit WRAP_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   start_stop_d;
    logic                   synced;
    logic                   tick_evt;
    logic                   ss_evt;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   count_en;
    logic                   at_max;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign tick_evt = synced & ~prev;
    assign ss_evt   = start_stop & ~start_stop_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            prev         <= 1'b0;
            start_stop_d <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], tick_in};
            prev         <= synced;
            start_stop_d <= start_stop;
        end
    end

    // Counting is decided on the pre-transition state, so a tick coinciding with stop still lands.
    assign count_en = tick_evt & (state == RUN) & ~clear;
    assign at_max   = (min_tens == 4'd5) && (min_ones == 4'd9) &&
                      (sec_tens == 4'd5) && (sec_ones == 4'd9);

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (ss_evt) begin
            state_nxt = (state == RUN) ? PAUSE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            running  <= 1'b0;
            wrap     <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);
            wrap    <= 1'b0;
            if (clear) begin
                sec_ones <= 4'd0;
                sec_tens <= 4'd0;
                min_ones <= 4'd0;
                min_tens <= 4'd0;
            end else if (count_en) begin
                if (at_max) begin
                    // Without wrap the count parks at 59:59 and further ticks are dropped.
                    if (WRAP_EN) begin
                        sec_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        min_ones <= 4'd0;
                        min_tens <= 4'd0;
                        wrap     <= 1'b1;
                    end
                end else if (sec_ones != 4'd9) begin
                    sec_ones <= sec_ones + 4'd1;
                end else begin
                    sec_ones <= 4'd0;
                    if (sec_tens != 4'd5) begin
                        sec_tens <= sec_tens + 4'd1;
                    end else begin
                        sec_tens <= 4'd0;
                        if (min_ones != 4'd9) begin
                            min_ones <= min_ones + 4'd1;
                        end else begin
                            min_ones <= 4'd0;
                            min_tens <= min_tens + 4'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_bcd_stopwatch.sv
// Bench for tick_bcd_stopwatch: wrapping and saturating instances share stimulus; a seconds-count model feeds a scoreboard.
module tb_tick_bcd_stopwatch;

    localparam int SS = 2;

    logic clk;
    logic rst;
    logic tick_in;
    logic start_stop;
    logic clear;

    logic [3:0] w_so, w_st, w_mo, w_mt;
    logic [3:0] s_so, s_st, s_mo, s_mt;
    logic       w_run, w_wrap, s_run, s_wrap;
    logic [15:0] w_dig, s_dig;

    assign w_dig = {w_mt, w_mo, w_st, w_so};
    assign s_dig = {s_mt, s_mo, s_st, s_so};

    tick_bcd_stopwatch #(.SYNC_STAGES(SS), .WRAP_EN(1'b1)) dut_w (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
        .sec_ones(w_so), .sec_tens(w_st), .min_ones(w_mo), .min_tens(w_mt),
        .running(w_run), .wrap(w_wrap)
    );

    tick_bcd_stopwatch #(.SYNC_STAGES(SS), .WRAP_EN(1'b0)) dut_s (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
        .sec_ones(s_so), .sec_tens(s_st), .min_ones(s_mo), .min_tens(s_mt),
        .running(s_run), .wrap(s_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic cmp1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%b want=%b", name, $time, act, exp);
        end
    endtask

    // Elapsed seconds rendered as MM:SS BCD.
    function automatic logic [15:0] to_bcd(input int c);
        logic [15:0] r;
        r[15:12] = 4'(c / 600);
        r[11:8]  = 4'((c / 60) % 10);
        r[7:4]   = 4'((c % 60) / 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    // Reference model: elapsed time as plain integers, ticks delayed by the synchroniser depth.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;
    typedef struct {
        int cw;
        int cs;
        bit ww;
        bit run;
    } exp_t;

    exp_t    q[$];
    mstate_t m_st = M_IDLE;
    int      m_cw = 0;
    int      m_cs = 0;
    bit      m_wrap = 1'b0;
    bit      hist[SS+1];
    bit      m_sprev = 1'b0;
    bit      tevt, sevt;

    always @(posedge clk) begin
        if (rst) begin
            m_st    = M_IDLE;
            m_cw    = 0;
            m_cs    = 0;
            m_wrap  = 1'b0;
            m_sprev = 1'b0;
            for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
        end else begin
            tevt   = hist[SS-1] && !hist[SS];
            sevt   = start_stop && !m_sprev;
            m_wrap = 1'b0;
            if (clear) begin
                m_st = M_IDLE;
                m_cw = 0;
                m_cs = 0;
            end else begin
                if (tevt && m_st == M_RUN) begin
                    if (m_cw == 3599) begin
                        m_cw   = 0;
                        m_wrap = 1'b1;
                    end else begin
                        m_cw = m_cw + 1;
                    end
                    if (m_cs < 3599) m_cs = m_cs + 1;
                end
                if (sevt) m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
            end
            for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = tick_in;
            m_sprev = start_stop;
        end
        q.push_back('{m_cw, m_cs, m_wrap, (m_st == M_RUN)});
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            cmp16("w_digits", w_dig, to_bcd(mon_e.cw));
            cmp1("w_wrap", w_wrap, mon_e.ww);
            cmp1("w_running", w_run, mon_e.run);
            cmp16("s_digits", s_dig, to_bcd(mon_e.cs));
            cmp1("s_wrap", s_wrap, 1'b0);
            cmp1("s_running", s_run, mon_e.run);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc($urandom_range(2, 5));
            tick_in = 1'b0;
            cyc($urandom_range(2, 5));
        end
    endtask

    task automatic ss_pulse();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        cyc(1);
    endtask

    task automatic spot(input string name, input logic [15:0] want, input logic want_run);
        cmp16(name, w_dig, want);
        cmp1({name, "_run"}, w_run, want_run);
    endtask

    initial begin
        rst        = 1'b1;
        tick_in    = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        spot("reset", 16'h0000, 1'b0);

        // Start and count five ticks of period 8.
        ss_pulse();
        for (int i = 0; i < 5; i++) begin
            tick_in = 1'b1;
            cyc(4);
            tick_in = 1'b0;
            cyc(4);
        end
        spot("five_ticks", 16'h0005, 1'b1);

        // Stop coincident with a tick event at 00:07.
        tick_n(2);
        spot("at_0007", 16'h0007, 1'b1);
        tick_in = 1'b1;
        cyc(2);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        cyc(1);
        tick_in = 1'b0;
        cyc(4);
        spot("coincide_stop", 16'h0008, 1'b0);
        tick_n(4);
        spot("paused_hold", 16'h0008, 1'b0);
        ss_pulse();
        tick_n(1);
        spot("resume", 16'h0009, 1'b1);

        // Carry chains.
        tick_n(50);
        spot("at_0059", 16'h0059, 1'b1);
        tick_n(1);
        spot("carry_0100", 16'h0100, 1'b1);
        tick_n(539);
        spot("at_0959", 16'h0959, 1'b1);
        tick_n(1);
        spot("carry_1000", 16'h1000, 1'b1);
        tick_n(154);
        spot("at_1234", 16'h1234, 1'b1);

        // Clear held with activity on the other inputs.
        clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_in    = 1'($urandom_range(0, 1));
            start_stop = 1'($urandom_range(0, 1));
            cyc(1);
            spot("clear_held", 16'h0000, 1'b0);
        end
        clear      = 1'b0;
        tick_in    = 1'b0;
        start_stop = 1'b0;
        cyc(4);
        tick_n(3);
        spot("idle_after_clear", 16'h0000, 1'b0);
        ss_pulse();
        cyc(3);
        spot("restart", 16'h0000, 1'b1);

        // Rollover and saturation.
        tick_n(3599);
        spot("at_5959", 16'h5959, 1'b1);
        cmp16("sat_at_5959", s_dig, 16'h5959);
        tick_n(1);
        spot("wrapped", 16'h0000, 1'b1);
        cmp16("sat_hold", s_dig, 16'h5959);
        tick_n(3);
        spot("after_wrap", 16'h0003, 1'b1);
        cmp16("sat_hold3", s_dig, 16'h5959);
        cmp1("sat_running", s_run, 1'b1);

        // Held start_stop gives one event; reset mid-run.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        start_stop = 1'b1;
        cyc(20);
        start_stop = 1'b0;
        cyc(2);
        spot("held_ss", 16'h0000, 1'b1);
        tick_n(201);
        spot("at_0321", 16'h0321, 1'b1);
        tick_in = 1'b1;
        rst     = 1'b1;
        cyc(1);
        spot("mid_reset", 16'h0000, 1'b0);
        cmp1("mid_reset_wrap", w_wrap, 1'b0);
        rst = 1'b0;
        cyc(6);
        spot("spurious_edge", 16'h0000, 1'b0);
        tick_in = 1'b0;
        cyc(3);

        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_bcd_stopwatch.md
Name: tick_bcd_stopwatch

Overview:
- MM:SS stopwatch that counts ticks from the frequency divider output (nominally 1 Hz).
- Sits directly downstream of the divider. The divided clock arrives as an ordinary data signal and is never used as a clock.
- The block synchronises it, detects its rising edges, and advances four cascaded BCD digits under a start/stop/clear control FSM.
- Digit outputs feed the display/scan stage.

Parameters:
- SYNC_STAGES, 2: flops in the tick_in synchroniser; legal values are 2 or more.
- WRAP_EN, 1: 1 means 59:59 wraps to 00:00 and pulses wrap; 0 means the count saturates at 59:59.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  divided clock from the divider; asynchronous to clk in phase.
- start_stop  input  1  control, synchronous to clk; a rising edge toggles run/pause.
- clear  input  1  synchronous level; while high, forces IDLE and zero.
- sec_ones  output  4  BCD seconds units, 0-9.
- sec_tens  output  4  BCD seconds tens, 0-5.
- min_ones  output  4  BCD minutes units, 0-9.
- min_tens  output  4  BCD minutes tens, 0-5.
- running  output  1  high while in the RUN state.
- wrap  output  1  one-cycle pulse on the 59:59 to 00:00 rollover.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- While rst is high at a clk edge:
  - all digits become 0 and running = 0, wrap = 0;
  - state = IDLE;
  - synchroniser flops, the tick edge register and the start_stop edge register are cleared to 0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then one more flop (prev).
  - tick_evt = synced & ~prev, combinational; it is high for exactly one clk cycle per tick_in rising edge.
  - Latency: if tick_in rises before clk edge 1, the digits change on edge SYNC_STAGES+1 (edge 3 at the default).
  - tick_in pulses narrower than one clk period may be missed. This is not required to be handled.
- start_stop edge: ss_evt = start_stop & ~start_stop_d, where start_stop_d is a 1-flop delay. A held-high start_stop gives one event only.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + ss_evt -> RUN.
  - RUN + ss_evt -> PAUSE.
  - PAUSE + ss_evt -> RUN.
  - Any state + clear -> IDLE.
- Priority, highest first: rst, clear, ss_evt/tick_evt.
- clear:
  - With clear high, digits are 0 on the next edge and stay 0; ss_evt and tick_evt are ignored.
  - After clear falls, the state is IDLE.
- Counting:
  - The count advances only when tick_evt = 1 and the current (pre-transition) state is RUN.
  - tick_evt and ss_evt in the same cycle while in RUN: the tick is counted and the state goes to PAUSE.
  - The same coincidence in IDLE or PAUSE: the tick is not counted and the state goes to RUN.
- Increment rule, one tick:
  - sec_ones 9 -> 0 with carry; sec_tens 5 -> 0 with carry; min_ones 9 -> 0 with carry; min_tens 5 -> 0.
  - All carries resolve in the same cycle; there are no intermediate illegal codes.
- Rollover at 59:59:
  - WRAP_EN=1: the next counted tick gives 00:00 and wrap = 1 for exactly that cycle; state stays RUN.
  - WRAP_EN=0: digits hold 59:59, further ticks are ignored, wrap stays 0, running stays 1.
- Outputs are registered. running reflects the state register, i.e. it goes high on the edge that enters RUN.
- Digits never hold a value outside the legal BCD ranges listed in Ports.
- Spurious edge at reset release: if tick_in is high when rst falls, a tick_evt occurs. It is harmless because the state is IDLE.
- Reset mid-count (rst in any state): all outputs return to reset values on that edge; no wrap pulse is generated.

Test Plan:
1. Reset, then one start_stop pulse, then 5 tick_in rising edges, with tick_in period = 8 clk -> 00:05 and running=1. Each increment lands on the 3rd clk edge after its tick_in rise.
2. Preload by ticking to 00:59, then 1 tick -> 01:00. Then tick to 09:59, then 1 tick -> 10:00. Check sec_ones/sec_tens carry in the same cycle.
3. WRAP_EN=1, running at 59:59, 1 tick -> 00:00 with wrap high for exactly 1 cycle. With WRAP_EN=0, 3 more ticks -> stays 59:59 and wrap never asserts.
4. Running at 00:07: start_stop pulse coincident with tick_evt -> 00:08 with state PAUSE; 4 further ticks -> stays 00:08. Next start_stop pulse -> RUN, and the following tick gives 00:09.
5. clear held high for 10 cycles during RUN at 12:34, with ticks and start_stop pulses applied -> 00:00 from the next edge on, running=0. After release, ticks do not count until a start_stop pulse.
6. Hold start_stop high for 20 cycles from IDLE -> exactly one transition, to RUN. Assert rst mid-run at 03:21 -> next edge gives 00:00, running=0, wrap=0.
